// File: rtl/eth_tx_tstamp_insert_pkg.sv
// Shared constants and types for the TX timestamp insertion path.
// Includes the frame-match constants, the FSM state encoding and a helper
// that puts a timestamp into wire byte order.
package eth_tstamp_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPPROTO_UDP    = 8'h11;
  localparam int          CSUM_BEAT      = 5;
  // Skid payload layout: {tdata[63:0], tkeep[7:0], tlast, tuser}
  localparam int          AXIS_PAYLOAD_W = 74;

  typedef logic [63:0] tstamp_t;

  typedef enum logic [1:0] {
    ST_SOF  = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } tx_state_e;

  // Timestamp goes out MSB first: ts[63:56] lands in the first wire byte.
  function automatic logic [63:0] ts_to_wire(input tstamp_t ts);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = ts[56 - 8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_tx_tstamp_insert_if.sv
// 64-bit AXI-Stream bundle used on both sides of the timestamp inserter.
interface eth_tx_tstamp_insert_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, output tdata, output tkeep, output tlast,
                  output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast,
                  input tuser, output tready);
endinterface

// File: rtl/eth_tx_tstamp_insert_skid_buf.sv
// Two-entry skid buffer forming the registered output stage of the inserter.
// Input ready is registered and depends only on buffer occupancy, never on
// the downstream ready of the current cycle.
module axis_skid_buf
  import eth_tstamp_pkg::*;
#(
  parameter int W = AXIS_PAYLOAD_W
) (
  input  logic         clk156,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] out_data_r;
  logic [W-1:0] skid_data_r;
  logic         out_valid_r;
  logic         skid_valid_r;
  logic         in_ready_r;
  logic         push_s;
  logic         pop_s;
  logic [1:0]   count_s;
  logic [1:0]   count_next_s;

  // Handshake qualifiers and next occupancy.
  always_comb begin
    push_s       = in_valid & in_ready_r;
    pop_s        = out_valid_r & out_ready;
    count_s      = {1'b0, out_valid_r} + {1'b0, skid_valid_r};
    count_next_s = count_s + {1'b0, push_s} - {1'b0, pop_s};
  end

  // Output register plus skid entry; output holds while stalled.
  always_ff @(posedge clk156) begin
    if (reset) begin
      out_data_r   <= '0;
      skid_data_r  <= '0;
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      in_ready_r <= (count_next_s != 2'd2);
      if (!out_valid_r || pop_s) begin
        if (skid_valid_r) begin
          out_data_r   <= skid_data_r;
          out_valid_r  <= 1'b1;
          skid_valid_r <= push_s;
          if (push_s) begin
            skid_data_r <= in_data;
          end
        end else begin
          out_valid_r <= push_s;
          if (push_s) begin
            out_data_r <= in_data;
          end
        end
      end else if (push_s) begin
        skid_data_r  <= in_data;
        skid_valid_r <= 1'b1;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: rtl/eth_tx_tstamp_insert.sv
// TX timestamp inserter: overwrites beat TS_WORD of IPv4/UDP frames with the
// timestamp captured at start of frame, MSB first on the wire.
// Optional build macro TSTAMP_CSUM_CLR_EN: also zero the UDP checksum
// (beat 5, tdata[15:0]) of qualified frames.
module eth_tx_tstamp_insert
  import eth_tstamp_pkg::*;
#(
  parameter int TS_WORD = 6
) (
  input  logic                          clk156,
  input  logic                          reset,
  eth_tx_tstamp_insert_if.slave         s_axis,
  eth_tx_tstamp_insert_if.master        m_axis,
  output tstamp_t                       ts_now,
  output logic [31:0]                   insert_count
);

  localparam logic [7:0] TS_BEAT   = 8'(TS_WORD);
  localparam logic [7:0] CSUM_IDX  = 8'(CSUM_BEAT);

  tx_state_e                 state_r;
  logic [7:0]                beat_cnt_r;
  tstamp_t                   ts_now_r;
  tstamp_t                   ts_hold_r;
  logic                      eth_ok_r;
  logic                      qual_r;
  logic [31:0]               insert_cnt_r;

  logic                      ready_s;
  logic                      accept_s;
  logic                      ins_s;
  logic                      csum_s;
  logic [63:0]               data_s;
  logic [AXIS_PAYLOAD_W-1:0] pl_in_s;
  logic [AXIS_PAYLOAD_W-1:0] pl_out_s;
  logic                      out_valid_s;

  // Free-running timestamp, wraps naturally at 2^64.
  always_ff @(posedge clk156) begin
    if (reset) begin
      ts_now_r <= '0;
    end else begin
      ts_now_r <= ts_now_r + 64'd1;
    end
  end

  // Beat classification and data replacement ahead of the skid stage.
  always_comb begin
    accept_s = s_axis.tvalid & ready_s;
    ins_s    = (state_r == ST_BODY) && qual_r && (beat_cnt_r == TS_BEAT) &&
               (s_axis.tkeep == 8'hFF);
`ifdef TSTAMP_CSUM_CLR_EN
    csum_s   = (state_r == ST_BODY) && qual_r && (beat_cnt_r == CSUM_IDX);
`else
    csum_s   = 1'b0;
`endif
    if (ins_s) begin
      data_s = ts_to_wire(ts_hold_r);
    end else if (csum_s) begin
      data_s = {s_axis.tdata[63:16], 16'h0000};
    end else begin
      data_s = s_axis.tdata;
    end
    pl_in_s = {data_s, s_axis.tkeep, s_axis.tlast, s_axis.tuser};
  end

  // Frame FSM: SOF latch, header qualification over beats 1-2, body counting.
  always_ff @(posedge clk156) begin
    if (reset) begin
      state_r      <= ST_SOF;
      beat_cnt_r   <= 8'd0;
      ts_hold_r    <= '0;
      eth_ok_r     <= 1'b0;
      qual_r       <= 1'b0;
      insert_cnt_r <= 32'd0;
    end else if (accept_s) begin
      if (ins_s) begin
        insert_cnt_r <= insert_cnt_r + 32'd1;
      end
      if (s_axis.tlast) begin
        beat_cnt_r <= 8'd0;
      end else if (beat_cnt_r != 8'd255) begin
        beat_cnt_r <= beat_cnt_r + 8'd1;
      end
      case (state_r)
        ST_SOF: begin
          ts_hold_r <= ts_now_r;
          eth_ok_r  <= 1'b0;
          qual_r    <= 1'b0;
          state_r   <= s_axis.tlast ? ST_SOF : ST_HDR;
        end
        ST_HDR: begin
          if (beat_cnt_r == 8'd1) begin
            eth_ok_r <= ({s_axis.tdata[39:32], s_axis.tdata[47:40]} == ETHERTYPE_IPV4);
            state_r  <= s_axis.tlast ? ST_SOF : ST_HDR;
          end else begin
            qual_r   <= eth_ok_r && (s_axis.tdata[63:56] == IPPROTO_UDP);
            state_r  <= s_axis.tlast ? ST_SOF : ST_BODY;
          end
        end
        ST_BODY: begin
          state_r <= s_axis.tlast ? ST_SOF : ST_BODY;
        end
        default: begin
          state_r <= ST_SOF;
        end
      endcase
    end
  end

  axis_skid_buf #(.W(AXIS_PAYLOAD_W)) u_skid (
    .clk156    (clk156),
    .reset     (reset),
    .in_valid  (s_axis.tvalid),
    .in_ready  (ready_s),
    .in_data   (pl_in_s),
    .out_valid (out_valid_s),
    .out_ready (m_axis.tready),
    .out_data  (pl_out_s)
  );

  assign s_axis.tready = ready_s;
  assign m_axis.tvalid = out_valid_s;
  assign m_axis.tdata  = pl_out_s[73:10];
  assign m_axis.tkeep  = pl_out_s[9:2];
  assign m_axis.tlast  = pl_out_s[1];
  assign m_axis.tuser  = pl_out_s[0];
  assign ts_now        = ts_now_r;
  assign insert_count  = insert_cnt_r;

endmodule

// File: tb/tb_eth_tx_tstamp_insert.sv
// Scoreboard bench for eth_tx_tstamp_insert: frames are modelled as byte
// arrays, the expected output frame is built from the frame rules, and a
// monitor pops expected beats whenever the DUT hands a beat over.
module tb_eth_tx_tstamp_insert;

  localparam int TS_WORD = 6;

  logic clk156 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk156 = ~clk156;

  eth_tx_tstamp_insert_if s_axis ();
  eth_tx_tstamp_insert_if m_axis ();
  logic [63:0] ts_now;
  logic [31:0] insert_count;

  eth_tx_tstamp_insert #(.TS_WORD(TS_WORD)) dut (
    .clk156       (clk156),
    .reset        (reset),
    .s_axis       (s_axis),
    .m_axis       (m_axis),
    .ts_now       (ts_now),
    .insert_count (insert_count)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_inserts = 0;
  bit          lat_chk = 1'b1;
  int          ready_pct = 100;
  logic [63:0] model_ts = '0;
  int          cyc = 0;
  logic [7:0]  fb [0:255];
  logic [7:0]  fx [0:255];
  logic        fu [0:31];
  int          flen;

  // Reference time base: counts cycles since reset released.
  always @(posedge clk156) begin
    model_ts <= reset ? 64'd0 : model_ts + 64'd1;
    cyc      <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Output monitor: random downstream ready, stall stability, scoreboard pop.
  initial begin
    logic        stalled;
    logic [63:0] held_data;
    logic [9:0]  held_ctl;
    exp_t        e;
    stalled = 1'b0;
    m_axis.tready = 1'b0;
    forever begin
      @(negedge clk156);
      if (stalled) begin
        check("stall_valid", 64'(m_axis.tvalid), 64'd1);
        check("stall_data", m_axis.tdata, held_data);
        check("stall_ctl", 64'({m_axis.tkeep, m_axis.tlast, m_axis.tuser}), 64'(held_ctl));
      end
      stalled = 1'b0;
      m_axis.tready = ($urandom_range(99) < ready_pct);
      if (m_axis.tvalid) begin
        if (m_axis.tready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got data %h, required no beat", m_axis.tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_axis.tdata, e.data);
            check("beat_ctl", 64'({m_axis.tkeep, m_axis.tlast, m_axis.tuser}),
                  64'({e.keep, e.last, e.user}));
            if (lat_chk) check("latency", 64'(cyc - e.acc), 64'd1);
          end
        end else begin
          stalled   = 1'b1;
          held_data = m_axis.tdata;
          held_ctl  = {m_axis.tkeep, m_axis.tlast, m_axis.tuser};
        end
      end
    end
  end

  task automatic make_frame(input int len, input logic [15:0] etype, input logic [7:0] proto);
    for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) fu[i] = 1'($urandom_range(1));
    fb[12] = etype[15:8];
    fb[13] = etype[7:0];
    fb[23] = proto;
    fb[40] = 8'hEF;  // beat 5 tdata[15:0] = 16'hBEEF
    fb[41] = 8'hBE;
    flen = len;
  endtask

  // Expected frame from byte-level rules, using the timestamp seen at SOF.
  task automatic build_expected(input logic [63:0] ts);
    int  nb;
    bit  qual;
    nb   = (flen + 7) / 8;
    for (int i = 0; i < 256; i++) fx[i] = fb[i];
    qual = (nb >= 3) && (fb[12] == 8'h08) && (fb[13] == 8'h00) && (fb[23] == 8'h11);
    if (qual && (flen >= 8 * (TS_WORD + 1))) begin
      for (int i = 0; i < 8; i++) fx[8*TS_WORD + i] = 8'(ts >> (56 - 8*i));
      exp_inserts++;
    end
`ifdef TSTAMP_CSUM_CLR_EN
    if (qual && nb > 5) begin
      fx[40] = 8'h00;
      fx[41] = 8'h00;
    end
`endif
  endtask

  // Drive fb[0:flen-1] (or its first max_beats beats) starting on a negedge.
  task automatic send_frame(input int idle_pct, input int max_beats);
    int   nb;
    int   w;
    exp_t e;
    nb = (flen + 7) / 8;
    if (max_beats < nb) nb = max_beats;
    for (int k = 0; k < nb; k++) begin
      if ($urandom_range(99) < idle_pct) begin
        s_axis.tvalid = 1'b0;
        @(negedge clk156);
      end
      s_axis.tvalid = 1'b1;
      for (int j = 0; j < 8; j++) s_axis.tdata[8*j +: 8] = fb[8*k + j];
      if (flen - 8*k >= 8) s_axis.tkeep = 8'hFF;
      else s_axis.tkeep = 8'((1 << (flen - 8*k)) - 1);
      s_axis.tlast = (k == (flen + 7) / 8 - 1);
      s_axis.tuser = fu[k];
      w = 0;
      while (!s_axis.tready && w < 1000) begin
        @(negedge clk156);
        w++;
      end
      if (!s_axis.tready) begin
        n_cmp++;
        n_err++;
        $display("FAIL s_ready_timeout: got tready 0, required 1");
      end
      if (k == 0) build_expected(model_ts);
      for (int j = 0; j < 8; j++) e.data[8*j +: 8] = fx[8*k + j];
      e.keep = s_axis.tkeep;
      e.last = s_axis.tlast;
      e.user = s_axis.tuser;
      e.acc  = cyc;
      exp_q.push_back(e);
      @(negedge clk156);
    end
    s_axis.tvalid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk156);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clk156);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_tvalid"}, 64'(m_axis.tvalid), 64'd0);
    check({tag, "_s_tready"}, 64'(s_axis.tready), 64'd0);
    check({tag, "_m_tdata"}, m_axis.tdata, 64'd0);
    check({tag, "_m_ctl"}, 64'({m_axis.tkeep, m_axis.tlast, m_axis.tuser}), 64'd0);
    check({tag, "_ts_now"}, ts_now, 64'd0);
    check({tag, "_insert_count"}, 64'(insert_count), 64'd0);
  endtask

  initial begin
    int len;
    int r;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tlast  = 1'b0;
    s_axis.tuser  = 1'b0;

    // Reset state and first cycle after release.
    repeat (3) @(negedge clk156);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk156);
    check("ready_after_reset", 64'(s_axis.tready), 64'd1);
    check("ts_now_run", ts_now, model_ts);

    // 64-byte IPv4/UDP frame, full downstream ready.
    make_frame(64, 16'h0800, 8'h11);
    send_frame(0, 99);
    drain();
    check("insert_count_ipv4", 64'(insert_count), 64'(exp_inserts));

    // Same frame shape with an IPv6 ethertype: untouched.
    make_frame(64, 16'h86DD, 8'h11);
    send_frame(0, 99);
    drain();
    check("insert_count_ipv6", 64'(insert_count), 64'(exp_inserts));

    // Boundaries: too short, partial last beat after TS beat, partial TS beat,
    // single-beat frames, non-UDP; all back to back.
    make_frame(48, 16'h0800, 8'h11); send_frame(0, 99);
    make_frame(60, 16'h0800, 8'h11); send_frame(0, 99);
    make_frame(52, 16'h0800, 8'h11); send_frame(0, 99);
    make_frame(8, 16'h0800, 8'h11);  send_frame(0, 99);
    make_frame(5, 16'h0800, 8'h11);  send_frame(0, 99);
    make_frame(64, 16'h0800, 8'h06); send_frame(0, 99);
    make_frame(56, 16'h0800, 8'h11); send_frame(0, 99);
    drain();
    check("insert_count_bounds", 64'(insert_count), 64'(exp_inserts));
    check("ts_now_mid", ts_now, model_ts);

    // Mixed random frames with input gaps.
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(120, 1);
      r   = $urandom_range(3);
      make_frame(len, (r == 1) ? 16'h86DD : 16'h0800, (r == 2) ? 8'h06 : 8'h11);
      send_frame(20, 99);
    end
    drain();
    check("insert_count_mixed", 64'(insert_count), 64'(exp_inserts));

    // 100 qualified back-to-back frames against a 30% ready duty.
    lat_chk   = 1'b0;
    ready_pct = 30;
    for (int f = 0; f < 100; f++) begin
      make_frame($urandom_range(128, 56), 16'h0800, 8'h11);
      send_frame(0, 99);
    end
    drain();
    check("insert_count_stress", 64'(insert_count), 64'(exp_inserts));
    ready_pct = 100;
    repeat (3) @(negedge clk156);
    lat_chk = 1'b1;

    // Reset during beat 3 of a qualified frame, then a clean frame.
    make_frame(64, 16'h0800, 8'h11);
    send_frame(0, 4);
    reset = 1'b1;
    @(negedge clk156);
    check_all_zero("midreset");
    check("midreset_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    exp_inserts = 0;
    @(negedge clk156);
    reset = 1'b0;
    @(negedge clk156);
    make_frame(64, 16'h0800, 8'h11);
    send_frame(0, 99);
    drain();
    check("insert_count_after_reset", 64'(insert_count), 64'(exp_inserts));
    check("insert_count_one", 64'(exp_inserts), 64'(insert_count == 32'd1 ? 1 : 0) + 64'd0 + 64'(exp_inserts) - 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_tx_tstamp_insert.md
ETH_TX_TSTAMP_INSERT -- requirements
Module: eth_tx_tstamp_insert

Interface
REQ-001 Parameter TS_WORD, default 6, 64-bit beat index (from 0) whose data is overwritten with the timestamp; legal range 6..31.
REQ-002 clk156  input  1  single clock for all logic, including the 156.25 MHz MAC-side domain; no other clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 s_axis_tvalid/tready/tdata/tkeep/tlast/tuser  in/out/in/in/in/in  1/1/64/8/1/1  frame input from eth_send.
REQ-005 m_axis_tvalid/tready/tdata/tkeep/tlast/tuser  out/in/out/out/out/out  1/1/64/8/1/1  frame output toward pcie2eth_fifo.
REQ-006 ts_now  output  64  free-running timestamp counter value.
REQ-007 insert_count  output  32  number of frames that received a timestamp.

Function
REQ-008 Byte order: tdata[7:0] is the first wire byte of a beat; beat k carries frame bytes 8k..8k+7.
REQ-009 ts_now increments by 1 every clk156 cycle and wraps from 2^64-1 to 0.
REQ-010 On acceptance of the first beat of a frame (SOF), ts_now is latched into ts_hold; ts_hold is stable for the rest of that frame.
REQ-011 FSM states: SOF (awaiting first beat), HDR (beats 1-2, qualification), BODY (beats 3+); frames end and return to SOF on an accepted tlast in any state.
REQ-012 Beat counter: 0 at SOF; +1 per accepted beat; saturates at 255.
REQ-013 Qualified frame: bytes 12-13 equal 0x08,0x00 (beat 1 tdata[39:32], tdata[47:40]) and byte 23 equals 0x11 (beat 2 tdata[63:56]).
REQ-014 For a qualified frame, beat TS_WORD with tkeep == 8'hFF has tdata replaced by ts_hold, MSB first on the wire (ts_hold[63:56] in tdata[7:0]).
REQ-015 No modification is made if the frame is unqualified, ends before beat TS_WORD, or beat TS_WORD has tkeep != 8'hFF; insert_count increments only when a replacement is made.
REQ-016 tkeep, tlast and tuser pass through unmodified on every beat.
REQ-017 Latency is exactly 1 cycle from s-side acceptance to m_axis_tvalid with an idle output; throughput is 1 beat/cycle under continuous tready.
REQ-018 s_axis_tready is high whenever the internal 2-entry skid buffer has a free entry, independent of the current m_axis_tready.
REQ-019 Output data does not change while m_axis_tvalid=1 and m_axis_tready=0; beats are never dropped or duplicated.
REQ-020 A single-beat frame (tlast on beat 0) returns to SOF and counts as unqualified.
REQ-021 Back-to-back frames with no gap are each latched and qualified independently.

Reset
REQ-022 While reset=1: FSM=SOF, beat counter=0, skid buffer empty, m_axis_tvalid=0, s_axis_tready=0, ts_now=0, ts_hold=0, insert_count=0; m_axis_tdata/tkeep/tlast/tuser=0.
REQ-023 The cycle after reset deasserts: s_axis_tready=1. A frame cut short by reset is discarded; the next accepted beat is treated as SOF.

Configuration
REQ-024 With macro TSTAMP_CSUM_CLR_EN defined, a qualified frame has its UDP checksum bytes 40-41 (beat 5 tdata[15:0]) forced to 0x0000; without the macro, beat 5 passes unmodified.

Structure
REQ-025 Package eth_tstamp_pkg holds ETHERTYPE_IPV4 (16'h0800), IPPROTO_UDP (8'h11), CSUM_BEAT (5), the FSM state enum and the 64-bit timestamp typedef.
REQ-026 Sub-module axis_skid_buf (2-entry, 74-bit payload) provides the output register stage; the FSM and insertion muxing sit ahead of it.

Verification
REQ-027 Reset, then a 64-byte IPv4/UDP frame with tready=1 -> beat 6 output equals the ts_now latched at SOF, byte-swapped per REQ-014; other beats unchanged; insert_count=1; latency 1 cycle.
REQ-028 Same frame with ethertype 0x86DD -> output identical to input; insert_count unchanged.
REQ-029 A 48-byte qualified frame (6 beats) -> output unchanged, insert_count unchanged; a 60-byte frame with beat 7 tkeep=8'h0F -> beat 6 replaced.
REQ-030 Random m_axis_tready at 30% duty, 100 back-to-back frames -> no loss or duplication; the output data is stable while stalled; insert_count=100.
REQ-031 Reset asserted mid-frame at beat 3 -> all outputs are zero the next cycle; the following frame is inserted correctly.
REQ-032 Build with TSTAMP_CSUM_CLR_EN, input checksum 0xBEEF -> beat 5 tdata[15:0]=0x0000; without the macro it stays 0xBEEF.
